// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: in-order imem requests with req/gnt/rvalid handshake,
// a small fetch buffer in front of ID, and EX redirect with in-flight kill.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
);

  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outst_cnt;
  logic [CW-1:0] kill_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   fifo_ir [FIFO_DEPTH];
  logic [31:0]   fifo_pc [FIFO_DEPTH];

  logic issue;
  logic live;
  logic fifo_empty;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  // Credit rule: buffered plus in-flight words never exceed the buffer size.
  assign imem_req   = rst & !ex_take_branch &
                      (({1'b0, outst_cnt} + {1'b0, fifo_cnt}) < DEPTH_EXT);
  assign imem_addr  = fetch_pc;
  assign issue      = imem_req & imem_gnt;
  assign live       = imem_rvalid & (kill_cnt == '0) & !ex_take_branch;
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !ex_take_branch & !id_stall & !fifo_empty;
  assign push       = live & (id_stall | !fifo_empty);

  // resp_pc is the issue PC of the oldest live in-flight word; responses are in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc         <= RESET_PC;
      resp_pc          <= RESET_PC;
      outst_cnt        <= '0;
      kill_cnt         <= '0;
      fifo_cnt         <= '0;
      head             <= '0;
      tail             <= '0;
      if_id_IR         <= NOP;
      if_id_PC         <= '0;
      if_id_valid_inst <= 1'b0;
    end else begin
      outst_cnt <= outst_cnt + CW'(issue) - CW'(imem_rvalid);
      if (ex_take_branch) begin
        fetch_pc         <= ex_target_pc;
        resp_pc          <= ex_target_pc;
        kill_cnt         <= outst_cnt - CW'(imem_rvalid);
        fifo_cnt         <= '0;
        head             <= '0;
        tail             <= '0;
        if_id_IR         <= NOP;
        if_id_valid_inst <= 1'b0;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid && kill_cnt != '0)
          kill_cnt <= kill_cnt - CW'(1);
        if (live)
          resp_pc <= resp_pc + 32'd4;
        if (push)
          tail <= next_ptr(tail);
        if (pop)
          head <= next_ptr(head);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        if (!id_stall) begin
          if (!fifo_empty) begin
            if_id_IR         <= fifo_ir[head];
            if_id_PC         <= fifo_pc[head];
            if_id_valid_inst <= 1'b1;
          end else if (live) begin
            if_id_IR         <= imem_rdata;
            if_id_PC         <= resp_pc;
            if_id_valid_inst <= 1'b1;
          end else begin
            if_id_IR         <= NOP;
            if_id_valid_inst <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir[tail] <= imem_rdata;
      fifo_pc[tail] <= resp_pc;
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && fifo_cnt == DEPTH_C));

  assert property (@(posedge clk) disable iff (!rst) kill_cnt <= outst_cnt);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order, one-cycle-latency memory model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_take_branch = 1'b0;
  logic [31:0] ex_target_pc = '0;
  logic        id_stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;

  int total = 0;
  int bad   = 0;

  logic [31:0] pend_q [$];
  bit          resp_en = 1'b1;
  bit          last_iss;
  logic [31:0] last_addr;

  if_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_take_branch   (ex_take_branch),
    .ex_target_pc     (ex_target_pc),
    .id_stall         (id_stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // One clock: present the oldest pending response, note any issue, advance the memory.
  task automatic tick();
    bit rsp;
    if (resp_en && pend_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    last_iss  = imem_req & imem_gnt;
    last_addr = imem_addr;
    rsp       = imem_rvalid;
    @(posedge clk);
    #1;
    if (rsp) void'(pend_q.pop_front());
    if (last_iss) pend_q.push_back(last_addr);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (if_id_IR !== 32'h13) begin bad++; $display("[TB] FAIL reset_ir: got %h exp %h", if_id_IR, 32'h13); end
    total++; if (if_id_PC !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h exp %h", if_id_PC, 32'h0); end
    total++; if (if_id_valid_inst !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b exp 0", if_id_valid_inst); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b exp 0", imem_req); end
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL release_req: got %b/%h exp 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    tick();
    total++; if (!last_iss || last_addr !== 32'h0) begin bad++; $display("[TB] FAIL stream_first_addr: got %b/%h exp 1/00000000", last_iss, last_addr); end
    total++; if (if_id_valid_inst !== 1'b0) begin bad++; $display("[TB] FAIL stream_first_valid: got %b exp 0", if_id_valid_inst); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (!last_iss || last_addr !== 32'(4 * (i + 1))) begin bad++; $display("[TB] FAIL stream_addr: got %b/%h exp 1/%h", last_iss, last_addr, 32'(4 * (i + 1))); end
      total++; if (if_id_IR !== word(32'(4 * i))) begin bad++; $display("[TB] FAIL stream_ir: got %h exp %h", if_id_IR, word(32'(4 * i))); end
      total++; if (if_id_PC !== 32'(4 * i)) begin bad++; $display("[TB] FAIL stream_pc: got %h exp %h", if_id_PC, 32'(4 * i)); end
      total++; if (if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid: got %b exp 1", if_id_valid_inst); end
    end
  endtask

  task automatic test_stall();
    id_stall = 1'b1;
    tick();
    total++; if (!last_iss || last_addr !== 32'h14) begin bad++; $display("[TB] FAIL stall_issue: got %b/%h exp 1/00000014", last_iss, last_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_req: got %b exp 0", imem_req); end
      total++; if (if_id_IR !== word(32'hC) || if_id_PC !== 32'hC || if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold: got %h/%h/%b exp %h/0000000c/1", if_id_IR, if_id_PC, if_id_valid_inst, word(32'hC)); end
    end
    id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (if_id_IR !== word(32'(32'h10 + 4 * i)) || if_id_PC !== 32'(32'h10 + 4 * i) || if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL stall_release: got %h/%h/%b exp %h/%h/1", if_id_IR, if_id_PC, if_id_valid_inst, word(32'(32'h10 + 4 * i)), 32'(32'h10 + 4 * i)); end
    end
  endtask

  task automatic test_redirect();
    rst = 1'b0;
    pend_q.delete();
    tick();
    rst = 1'b1;
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h10;
    resp_en        = 1'b0;
    tick();
    ex_take_branch = 1'b0;
    tick();
    total++; if (!last_iss || last_addr !== 32'h10) begin bad++; $display("[TB] FAIL redir_issue0: got %b/%h exp 1/00000010", last_iss, last_addr); end
    tick();
    total++; if (!last_iss || last_addr !== 32'h14) begin bad++; $display("[TB] FAIL redir_issue1: got %b/%h exp 1/00000014", last_iss, last_addr); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL redir_credit: got %b exp 0", imem_req); end
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h100;
    tick();
    total++; if (last_iss !== 1'b0) begin bad++; $display("[TB] FAIL redir_noissue: got %b exp 0", last_iss); end
    ex_take_branch = 1'b0;
    resp_en        = 1'b1;
    tick();
    total++; if (last_iss !== 1'b0 || if_id_valid_inst !== 1'b0) begin bad++; $display("[TB] FAIL redir_kill0: got iss %b valid %b exp 0/0", last_iss, if_id_valid_inst); end
    tick();
    total++; if (!last_iss || last_addr !== 32'h100 || if_id_valid_inst !== 1'b0) begin bad++; $display("[TB] FAIL redir_kill1: got %b/%h valid %b exp 1/00000100 valid 0", last_iss, last_addr, if_id_valid_inst); end
    tick();
    total++; if (if_id_IR !== word(32'h100) || if_id_PC !== 32'h100 || if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL redir_target: got %h/%h/%b exp %h/00000100/1", if_id_IR, if_id_PC, if_id_valid_inst, word(32'h100)); end
  endtask

  task automatic test_redirect_stall();
    id_stall       = 1'b1;
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h300;
    tick();
    total++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== 32'h13) begin bad++; $display("[TB] FAIL rs_drop: got %h/%b exp 00000013/0", if_id_IR, if_id_valid_inst); end
    ex_target_pc = 32'h200;
    tick();
    total++; if (if_id_valid_inst !== 1'b0) begin bad++; $display("[TB] FAIL rs_b2b_valid: got %b exp 0", if_id_valid_inst); end
    ex_take_branch = 1'b0;
    id_stall       = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("[TB] FAIL rs_resume: got %b/%h exp 1/00000200", imem_req, imem_addr); end
    tick();
    tick();
    total++; if (if_id_IR !== word(32'h200) || if_id_PC !== 32'h200 || if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL rs_target: got %h/%h/%b exp %h/00000200/1", if_id_IR, if_id_PC, if_id_valid_inst, word(32'h200)); end
  endtask

  task automatic test_gnt_wrap();
    imem_gnt = 1'b0;
    tick();
    total++; if (if_id_IR !== word(32'h204) || if_id_PC !== 32'h204) begin bad++; $display("[TB] FAIL gnt_drain: got %h/%h exp %h/00000204", if_id_IR, if_id_PC, word(32'h204)); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h208 || last_iss !== 1'b0) begin bad++; $display("[TB] FAIL gnt_hold: got %b/%h iss %b exp 1/00000208 iss 0", imem_req, imem_addr, last_iss); end
    end
    imem_gnt = 1'b1;
    tick();
    total++; if (!last_iss || last_addr !== 32'h208) begin bad++; $display("[TB] FAIL gnt_accept: got %b/%h exp 1/00000208", last_iss, last_addr); end
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'hFFFF_FFFC;
    tick();
    ex_take_branch = 1'b0;
    tick();
    total++; if (!last_iss || last_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_issue: got %b/%h exp 1/fffffffc", last_iss, last_addr); end
    #1;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_addr: got %h exp 00000000", imem_addr); end
    tick();
    total++; if (if_id_IR !== word(32'hFFFF_FFFC) || if_id_PC !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_last: got %h/%h exp %h/fffffffc", if_id_IR, if_id_PC, word(32'hFFFF_FFFC)); end
    tick();
    total++; if (if_id_IR !== word(32'h0) || if_id_PC !== 32'h0 || if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL wrap_first: got %h/%h/%b exp %h/00000000/1", if_id_IR, if_id_PC, if_id_valid_inst, word(32'h0)); end
  endtask

  task automatic test_reset_midstream();
    id_stall = 1'b1;
    tick();
    tick();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_full: got %b exp 0", imem_req); end
    rst = 1'b0;
    pend_q.delete();
    id_stall = 1'b0;
    tick();
    total++; if (if_id_IR !== 32'h13 || if_id_PC !== 32'h0 || if_id_valid_inst !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset: got %h/%h/%b req %b exp 00000013/00000000/0 req 0", if_id_IR, if_id_PC, if_id_valid_inst, imem_req); end
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL mid_restart: got %b/%h exp 1/00000000", imem_req, imem_addr); end
    tick();
    tick();
    total++; if (if_id_IR !== word(32'h0) || if_id_PC !== 32'h0 || if_id_valid_inst !== 1'b1) begin bad++; $display("[TB] FAIL mid_first: got %h/%h/%b exp %h/00000000/1", if_id_IR, if_id_PC, if_id_valid_inst, word(32'h0)); end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_gnt_wrap();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
